// File: rtl/primitive_sequencer.sv
// Primitive sequencer: buffers SETVERTEX words between Start/EndPrimitive and streams them on Draw.
// Optional feature: define PRIM_REPLAY_EN to keep a drawn primitive for re-streaming on a later Draw.
module primitive_sequencer #(
  parameter int VTX_DEPTH = 16,
  parameter int VTX_WIDTH = 32,
  parameter int PTR_WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 StartPrimitive,
  input  logic [3:0]           PrimitiveType,
  input  logic                 VertexValid,
  input  logic [VTX_WIDTH-1:0] Vertex,
  input  logic                 EndPrimitive,
  input  logic                 Draw,
  output logic [VTX_WIDTH-1:0] OutVertex,
  output logic [3:0]           OutPrimType,
  output logic                 OutValid,
  output logic                 OutLast,
  input  logic                 OutReady,
  output logic                 Busy,
  output logic [PTR_WIDTH:0]   VtxCount,
  output logic                 ErrFlag
);

  localparam logic [PTR_WIDTH:0]   DEPTH_C  = (PTR_WIDTH+1)'(VTX_DEPTH);
  localparam logic [PTR_WIDTH:0]   ONE_C    = {{PTR_WIDTH{1'b0}}, 1'b1};
  localparam logic [PTR_WIDTH:0]   ZERO_C   = {(PTR_WIDTH+1){1'b0}};
  localparam logic [PTR_WIDTH-1:0] PZERO_C  = {PTR_WIDTH{1'b0}};
  localparam logic [PTR_WIDTH-1:0] PONE_C   = {{(PTR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CLOSED  = 2'd2,
    DRAWING = 2'd3
  } state_t;

  state_t                 state_r, state_next_s;
  logic [PTR_WIDTH:0]     count_r, count_next_s;
  logic [PTR_WIDTH-1:0]   rd_ptr_r, rd_ptr_next_s;
  logic [3:0]             type_r, type_next_s;
  logic                   err_r, err_next_s;
  logic [VTX_WIDTH-1:0]   buf_r [VTX_DEPTH];
  logic [VTX_WIDTH-1:0]   out_vertex_r;
  logic                   out_valid_r;
  logic                   out_last_r;

  logic                   wr_en_s;
  logic                   load_en_s;
  logic [PTR_WIDTH-1:0]   load_addr_s;
  logic                   load_last_s;
  logic [PTR_WIDTH-1:0]   next_ptr_s;
  logic                   any_cmd_s;

  assign any_cmd_s  = StartPrimitive | VertexValid | EndPrimitive | Draw;
  assign next_ptr_s = rd_ptr_r + PONE_C;

  // Next-state, buffer-write and output-load decisions
  always_comb begin
    state_next_s  = state_r;
    count_next_s  = count_r;
    rd_ptr_next_s = rd_ptr_r;
    type_next_s   = type_r;
    err_next_s    = err_r;
    wr_en_s       = 1'b0;
    load_en_s     = 1'b0;
    load_addr_s   = PZERO_C;
    load_last_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (StartPrimitive) begin
          type_next_s  = PrimitiveType;
          count_next_s = ZERO_C;
          state_next_s = COLLECT;
        end else begin
          state_next_s = IDLE;
        end
      end
      COLLECT: begin
        if (StartPrimitive) begin
          type_next_s  = PrimitiveType;
          count_next_s = ZERO_C;
        end else begin
          if (VertexValid) begin
            if (count_r < DEPTH_C) begin
              wr_en_s      = 1'b1;
              count_next_s = count_r + ONE_C;
            end else begin
              err_next_s = 1'b1;
            end
          end else begin
            wr_en_s = 1'b0;
          end
          if (EndPrimitive) begin
            state_next_s = CLOSED;
          end else begin
            state_next_s = COLLECT;
          end
          if (Draw) begin
            err_next_s = 1'b1;
          end else begin
            err_next_s = err_next_s;
          end
        end
      end
      CLOSED: begin
        if (VertexValid) begin
          err_next_s = 1'b1;
        end else begin
          err_next_s = err_r;
        end
        if (StartPrimitive) begin
          type_next_s  = PrimitiveType;
          count_next_s = ZERO_C;
          state_next_s = COLLECT;
        end else if (Draw) begin
          if (count_r != ZERO_C) begin
            rd_ptr_next_s = PZERO_C;
            state_next_s  = DRAWING;
            load_en_s     = 1'b1;
            load_addr_s   = PZERO_C;
            load_last_s   = (count_r == ONE_C);
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = CLOSED;
        end
      end
      DRAWING: begin
        if (any_cmd_s) begin
          err_next_s = 1'b1;
        end else begin
          err_next_s = err_r;
        end
        if (OutReady) begin
          if (out_last_r) begin
`ifdef PRIM_REPLAY_EN
            state_next_s = CLOSED;
`else
            state_next_s = IDLE;
            count_next_s = ZERO_C;
`endif
          end else begin
            rd_ptr_next_s = next_ptr_s;
            load_en_s     = 1'b1;
            load_addr_s   = next_ptr_s;
            load_last_s   = (({1'b0, next_ptr_s} + ONE_C) == count_r);
          end
        end else begin
          state_next_s = DRAWING;
        end
      end
      default: begin
        state_next_s = IDLE;
        count_next_s = ZERO_C;
      end
    endcase
  end

  // Control state and registered stream outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r      <= IDLE;
      count_r      <= ZERO_C;
      rd_ptr_r     <= PZERO_C;
      type_r       <= 4'd0;
      err_r        <= 1'b0;
      out_valid_r  <= 1'b0;
      out_last_r   <= 1'b0;
      out_vertex_r <= {VTX_WIDTH{1'b0}};
    end else begin
      state_r     <= state_next_s;
      count_r     <= count_next_s;
      rd_ptr_r    <= rd_ptr_next_s;
      type_r      <= type_next_s;
      err_r       <= err_next_s;
      out_valid_r <= (state_next_s == DRAWING);
      if (load_en_s) begin
        out_vertex_r <= buf_r[load_addr_s];
        out_last_r   <= load_last_s;
      end else if (state_next_s != DRAWING) begin
        out_last_r <= 1'b0;
      end
    end
  end

  // Vertex storage; contents beyond count are don't-care, so no reset
  always_ff @(posedge CLK) begin
    if (!RESET && wr_en_s) begin
      buf_r[count_r[PTR_WIDTH-1:0]] <= Vertex;
    end
  end

  assign OutVertex   = out_vertex_r;
  assign OutPrimType = type_r;
  assign OutValid    = out_valid_r;
  assign OutLast     = out_last_r;
  assign Busy        = out_valid_r;
  assign VtxCount    = count_r;
  assign ErrFlag     = err_r;

endmodule

// File: tb/tb_primitive_sequencer.sv
// Self-checking bench for primitive_sequencer: queue-based reference model plus directed literal checks.
module tb_primitive_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  ptype = 4'd0;
  logic        vv = 1'b0;
  logic [31:0] vtx = 32'd0;
  logic        endp = 1'b0;
  logic        draw = 1'b0;
  logic        ready = 1'b1;
  logic [31:0] out_vertex;
  logic [3:0]  out_type;
  logic        out_valid, out_last, busy, err_flag;
  logic [4:0]  vtx_count;

  primitive_sequencer dut (
    .CLK(CLK), .RESET(RESET), .StartPrimitive(start), .PrimitiveType(ptype),
    .VertexValid(vv), .Vertex(vtx), .EndPrimitive(endp), .Draw(draw),
    .OutVertex(out_vertex), .OutPrimType(out_type), .OutValid(out_valid),
    .OutLast(out_last), .OutReady(ready), .Busy(busy), .VtxCount(vtx_count),
    .ErrFlag(err_flag)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  // reference model: 0 idle, 1 collecting, 2 closed, 3 streaming
  int          m_mode = 0;
  logic [31:0] m_q[$];
  logic [3:0]  m_type = 4'd0;
  bit          m_err = 1'b0;
  int          m_rd = 0;

  logic [31:0] got_v[$];
  bit          got_l[$];
  logic [3:0]  got_t[$];
  int          busy_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (RESET) begin
      m_mode = 0; m_q.delete(); m_type = 4'd0; m_err = 1'b0; m_rd = 0;
    end else begin
      case (m_mode)
        0: if (start) begin m_type = ptype; m_q.delete(); m_mode = 1; end
        1: begin
          if (start) begin
            m_q.delete(); m_type = ptype;
          end else begin
            if (vv) begin
              if (m_q.size() < 16) m_q.push_back(vtx);
              else m_err = 1'b1;
            end
            if (endp) m_mode = 2;
            if (draw) m_err = 1'b1;
          end
        end
        2: begin
          if (vv) m_err = 1'b1;
          if (start) begin
            m_q.delete(); m_type = ptype; m_mode = 1;
          end else if (draw) begin
            if (m_q.size() > 0) begin m_mode = 3; m_rd = 0; end
            else m_mode = 0;
          end
        end
        3: begin
          if (start || vv || endp || draw) m_err = 1'b1;
          if (ready) begin
            if (m_rd == m_q.size() - 1) begin
`ifdef PRIM_REPLAY_EN
              m_mode = 2;
`else
              m_mode = 0;
              m_q.delete();
`endif
            end else begin
              m_rd++;
            end
          end
        end
        default: m_mode = 0;
      endcase
    end
  endtask

  // Single compare point: DUT outputs against the model every cycle
  always @(negedge CLK) begin
    if (chk_on) begin
      chk("valid", 32'(out_valid), 32'(m_mode == 3));
      chk("busy", 32'(busy), 32'(m_mode == 3));
      chk("vtxcount", 32'(vtx_count), 32'(m_q.size()));
      chk("errflag", 32'(err_flag), 32'(m_err));
      if (m_mode == 3 && out_valid) begin
        chk("outvertex", out_vertex, m_q[m_rd]);
        chk("outlast", 32'(out_last), 32'(m_rd == m_q.size() - 1));
        chk("outtype", 32'(out_type), 32'(m_type));
      end
      if (out_valid && ready) begin
        got_v.push_back(out_vertex);
        got_l.push_back(out_last);
        got_t.push_back(out_type);
      end
      if (busy) busy_cnt++;
    end
  end

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic cmd_start(input logic [3:0] t);
    start = 1'b1; ptype = t; tick(); start = 1'b0;
  endtask
  task automatic cmd_vtx(input logic [31:0] v);
    vv = 1'b1; vtx = v; tick(); vv = 1'b0;
  endtask
  task automatic cmd_end();
    endp = 1'b1; tick(); endp = 1'b0;
  endtask
  task automatic cmd_draw();
    draw = 1'b1; tick(); draw = 1'b0;
  endtask
  task automatic do_reset();
    RESET = 1'b1; tick(); tick(); RESET = 1'b0;
  endtask
  task automatic clear_log();
    got_v.delete(); got_l.delete(); got_t.delete(); busy_cnt = 0;
  endtask
  task automatic drain(input string name);
    int n = 0;
    while (m_mode == 3 && n < 200) begin tick(); n++; end
    if (m_mode == 3) chk({name, "_drain_timeout"}, 32'd1, 32'd0);
    repeat (3) tick();
  endtask

  initial begin
    logic [31:0] t1v [3];
    logic [2:0] lastbits;
    t1v[0] = 32'h00010002; t1v[1] = 32'h00030004; t1v[2] = 32'h00050006;

    tick(); tick();
    chk_on = 1'b1;
    tick(); RESET = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_flag), 32'd0);
    chk("rst_count", 32'(vtx_count), 32'd0);
    chk("rst_vertex", out_vertex, 32'd0);
    chk("rst_type", 32'(out_type), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);

    // 1: three vertices, ready always high
    clear_log();
    ready = 1'b1;
    cmd_start(4'd3);
    for (int i = 0; i < 3; i++) cmd_vtx(t1v[i]);
    cmd_end();
    cmd_draw();
    drain("t1");
    chk("t1_beats", 32'(got_v.size()), 32'd3);
    for (int i = 0; i < 3; i++) chk("t1_data", got_v[i], t1v[i]);
    lastbits = {got_l[2], got_l[1], got_l[0]};
    chk("t1_last", 32'(lastbits), 32'b100);
    chk("t1_type", 32'(got_t[0]), 32'd3);
    chk("t1_busy_cycles", 32'(busy_cnt), 32'd3);
    chk("t1_idle", 32'(busy), 32'd0);

    // 6: repeat Draw
    clear_log();
    cmd_draw();
    drain("t6");
`ifdef PRIM_REPLAY_EN
    chk("t6_beats", 32'(got_v.size()), 32'd3);
    for (int i = 0; i < 3; i++) chk("t6_data", got_v[i], t1v[i]);
`else
    chk("t6_beats", 32'(got_v.size()), 32'd0);
`endif

    // 2: ready toggling 1,0,0,1,1
    do_reset();
    clear_log();
    cmd_start(4'd3);
    for (int i = 0; i < 3; i++) cmd_vtx(t1v[i]);
    cmd_end();
    cmd_draw();
    begin
      bit pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 5; i++) begin ready = pat[i]; tick(); end
    end
    ready = 1'b1;
    drain("t2");
    chk("t2_beats", 32'(got_v.size()), 32'd3);
    for (int i = 0; i < 3; i++) chk("t2_data", got_v[i], t1v[i]);
    lastbits = {got_l[2], got_l[1], got_l[0]};
    chk("t2_last", 32'(lastbits), 32'b100);

    // 3: overflow with 17 vertices
    do_reset();
    clear_log();
    cmd_start(4'd1);
    for (int i = 0; i < 17; i++) cmd_vtx(32'h1000_0000 + 32'(i));
    cmd_end();
    chk("t3_err", 32'(err_flag), 32'd1);
    chk("t3_count", 32'(vtx_count), 32'd16);
    cmd_draw();
    drain("t3");
    chk("t3_beats", 32'(got_v.size()), 32'd16);
    for (int i = 0; i < 16; i++) chk("t3_data", got_v[i], 32'h1000_0000 + 32'(i));
    chk("t3_err_sticky", 32'(err_flag), 32'd1);

    // 4: restart discards earlier vertices
    do_reset();
    clear_log();
    cmd_start(4'd2);
    cmd_vtx(32'h11112222);
    cmd_vtx(32'h33334444);
    cmd_start(4'd5);
    cmd_vtx(32'hAAAA5555);
    cmd_end();
    cmd_draw();
    drain("t4");
    chk("t4_beats", 32'(got_v.size()), 32'd1);
    chk("t4_data", got_v[0], 32'hAAAA5555);
    chk("t4_type", 32'(got_t[0]), 32'd5);
    chk("t4_last", 32'(got_l[0]), 32'd1);

    // 5: reset during beat 2 of a 4-vertex draw
    do_reset();
    clear_log();
    cmd_start(4'd7);
    for (int i = 0; i < 4; i++) cmd_vtx(32'h0000_0100 + 32'(i));
    cmd_end();
    cmd_draw();
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_count", 32'(vtx_count), 32'd0);
    chk("t5_err", 32'(err_flag), 32'd0);
    repeat (2) tick();

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      int r;
      start = 1'b0; vv = 1'b0; endp = 1'b0; draw = 1'b0;
      RESET = ($urandom_range(0, 299) == 0);
      ready = ($urandom_range(0, 3) != 0);
      vtx = $urandom;
      ptype = 4'($urandom);
      r = $urandom_range(0, 99);
      if (r < 30) begin
      end else if (r < 35) start = 1'b1;
      else if (r < 70) vv = 1'b1;
      else if (r < 78) endp = 1'b1;
      else if (r < 82) begin vv = 1'b1; endp = 1'b1; end
      else if (r < 92) draw = 1'b1;
      tick();
    end
    start = 1'b0; vv = 1'b0; endp = 1'b0; draw = 1'b0; RESET = 1'b0; ready = 1'b1;
    repeat (40) tick();

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
